nios2_hello_ram_arbiter: RTL and testbench
==========================================

# nios2_hello_ram_arbiter

Two-master arbiter that shares the single-port on-chip program/data RAM (32-bit words, 13-bit word address, 5120 words, byte enables, one-cycle read latency) between the Nios II data master (m0) and a secondary master (m1, DMA or test loader). It sits directly in front of the RAM slave port. It provides:
- round-robin arbitration with a per-owner burst limit and a lock override;
- read-data-valid tracking;
- out-of-range address protection, with a sticky error capture.

## Interface
Parameters:
- ADDR_W, 13, word-address width
- DEPTH, 5120, number of implemented words; addresses >= DEPTH are out of range
- MAX_BURST, 8, maximum consecutive grants to one owner while the other master is requesting (range 1..255)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mN_address  in  ADDR_W  word address (N = 0, 1; identical port sets)
- mN_byteenable  in  4  byte lanes for writes
- mN_read  in  1  read request
- mN_write  in  1  write request; if read and write are asserted together, the access is treated as a write
- mN_writedata  in  32  write data
- mN_lock  in  1  keep the grant past MAX_BURST while requesting
- mN_waitrequest  out  1  request not accepted this cycle
- mN_readdata  out  32  read data, valid only with readdatavalid
- mN_readdatavalid  out  1  read data returned
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  4  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  32  to RAM
- ram_clken  out  1  to RAM; tied to 1
- ram_readdata  in  32  from RAM, unregistered q output
- ram_reset_req  in  1  RAM clock-enable gate; while high, nothing is granted
- err_clear  in  1  synchronous clear of the error capture
- err_flag  out  1  sticky out-of-range flag
- err_addr  out  ADDR_W  address of the first out-of-range access since the last clear
- err_master  out  1  master that caused the first error

## Operation
State registers:
- owner: NONE, M0 or M1
- last: master granted most recently
- run_cnt: 8 bits
- rd_pend[1:0]
- err_flag, err_addr, err_master

Reset values:
- owner = NONE, last = M1 (so M0 has first priority), run_cnt = 0, rd_pend = 0
- err_flag = 0, err_addr = 0, err_master = 0
- Combinational outputs at reset: both readdatavalid = 0, ram_chipselect = 0, ram_write = 0. Each waitrequest equals that master's request.

Grant decision (combinational, every cycle):
- reqN = mN_read | mN_write.
- If ram_reset_req = 1: no grant.
- Else the owner keeps the grant if it is still requesting and any of these holds:
  - the other master is idle;
  - run_cnt < MAX_BURST;
  - the owner's lock is asserted.
- Otherwise, if both masters request, grant the master that is not `last`. If exactly one requests, grant it. If neither requests, no grant.

Outputs under the grant:
- mN_waitrequest = reqN & ~grantN.
- ram_* are muxed from the granted master. With no grant, ram_address, ram_byteenable and ram_writedata come from m0.
- ram_chipselect = grant_any & (address < DEPTH).
- ram_write = ram_chipselect & granted write.

Clock-edge updates:
- When grantN: owner <= N and last <= N. run_cnt <= 1 if the owner changed, else run_cnt + 1, saturating at 255.
- With no grant: owner <= NONE, run_cnt <= 0.
- rd_pend[N] <= grantN & read & ~write.

Read return:
- mN_readdatavalid = rd_pend[N].
- mN_readdata = ram_readdata, or 0 if the read was out of range. The range status is registered together with rd_pend.

Error capture:
- A granted access with address >= DEPTH completes normally from the master's view (no hang). A write to such an address is dropped; a read returns 0.
- If err_flag = 0 at that point: set err_flag and capture err_addr and err_master.
- err_clear clears all three fields. If err_clear and a new error occur in the same cycle, the new error is captured (set wins).

## Timing
- Uncontended access is accepted with zero wait states.
- Read accepted at edge N: readdatavalid is high in cycle N+1, with data taken from ram_readdata in that cycle.
- Back-to-back reads from one master give one result per cycle. Pipelining across masters is allowed; each master's valid pulses only for its own reads.
- Writes take effect at the accepting edge.
- Asynchronous reset mid-read drops the pending readdatavalid. No response is later produced for that read.
- When ram_reset_req rises, new grants stop in the same cycle. A read accepted in the previous cycle still returns its readdatavalid.
- Contention worst case: a master waits at most MAX_BURST cycles, unless the owner holds lock.

## Test plan
- m0 alone writes 0xA5A5_1234 to 0x0010 with byteenable 0xF, then reads 0x0010 → zero waitrequest; m0_readdatavalid is high exactly one cycle after the read is accepted, with readdata = 0xA5A5_1234.
- Both masters request continuously from reset, MAX_BURST = 8 → m0 gets 8 grants, then m1 gets 8, alternating; neither waitrequest stays high for more than 8 cycles.
- m1 asserts lock while owner, with m0 requesting for 20 cycles → m1 holds the grant all 20 cycles. Lock drops with run_cnt ≥ 8 → m0 is granted the next cycle.
- m0 writes to 5120, then m1 reads 6000 → ram_chipselect stays 0; m1 readdata = 0 with valid. err_flag = 1, err_addr = 5120, err_master = 0. err_clear → all three return to 0.
- m0 and m1 issue alternating single reads → each master receives only its own readdatavalid pulses, with the correct data, in the cycle after its acceptance.
- Assert reset in the cycle after a read is accepted → readdatavalid stays 0 and owner returns to NONE. ram_reset_req held high → both waitrequests follow their requests and ram_chipselect = 0.

Source files
------------

// File: rtl/nios2_hello_ram_arbiter_if.sv
// Avalon-style master port bundle for one requester of the shared program/data RAM.
interface nios2_hello_ram_arbiter_if #(
   parameter int ADDR_W = 13
) ();
   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic              lock;
   logic              waitrequest;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata, lock,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata, lock,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/nios2_hello_ram_arbiter.sv
// Round-robin arbiter placing the Nios II data master (m0) and a secondary master (m1)
// in front of a single-port RAM, with burst limiting, lock, and out-of-range protection.
module nios2_hello_ram_arbiter #(
   parameter int ADDR_W    = 13,
   parameter int DEPTH     = 5120,
   parameter int MAX_BURST = 8
) (
   input  logic                clk,
   input  logic                reset,
   nios2_hello_ram_arbiter_if.slave m0,
   nios2_hello_ram_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [3:0]          ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [31:0]         ram_writedata,
   output logic                ram_clken,
   input  logic [31:0]         ram_readdata,
   input  logic                ram_reset_req,
   input  logic                err_clear,
   output logic                err_flag,
   output logic [ADDR_W-1:0]   err_addr,
   output logic                err_master
);
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_t;

   localparam logic [7:0]  BURST_LIM = 8'(MAX_BURST);
   localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

   owner_t     owner_r;
   logic       last_r;
   logic [7:0] run_cnt_r;
   logic [1:0] rd_pend_r;
   logic [1:0] rd_oor_r;

   logic req0_s, req1_s;
   logic grant0_s, grant1_s, grant_any_s;
   logic in_range_s, gnt_write_s, gnt_read_s, err_event_s;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign req0_s      = m0.read | m0.write;
   assign req1_s      = m1.read | m1.write;
   assign grant_any_s = grant0_s | grant1_s;

   // Grant decision: owner retention first, then round-robin on contention.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (reset || ram_reset_req) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (owner_r == OWN_M0 && req0_s &&
                   (!req1_s || run_cnt_r < BURST_LIM || m0.lock)) begin
         grant0_s = 1'b1;
      end else if (owner_r == OWN_M1 && req1_s &&
                   (!req0_s || run_cnt_r < BURST_LIM || m1.lock)) begin
         grant1_s = 1'b1;
      end else if (req0_s && req1_s) begin
         if (last_r) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else if (req0_s) begin
         grant0_s = 1'b1;
      end else if (req1_s) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // RAM-side mux; m0 drives the address/data buses whenever m1 is not granted.
   always_comb begin
      ram_address    = m0.address;
      ram_byteenable = m0.byteenable;
      ram_writedata  = m0.writedata;
      gnt_write_s    = grant0_s & m0.write;
      gnt_read_s     = grant0_s & m0.read & ~m0.write;
      if (grant1_s) begin
         ram_address    = m1.address;
         ram_byteenable = m1.byteenable;
         ram_writedata  = m1.writedata;
         gnt_write_s    = m1.write;
         gnt_read_s     = m1.read & ~m1.write;
      end else begin
         gnt_write_s    = grant0_s & m0.write;
      end
   end

   assign in_range_s     = 32'(ram_address) < DEPTH_W;
   assign err_event_s    = grant_any_s & ~in_range_s;
   assign ram_chipselect = grant_any_s & in_range_s;
   assign ram_write      = ram_chipselect & gnt_write_s;
   assign ram_clken      = 1'b1;

   assign m0.waitrequest   = req0_s & ~grant0_s;
   assign m1.waitrequest   = req1_s & ~grant1_s;
   assign m0.readdatavalid = rd_pend_r[0];
   assign m1.readdatavalid = rd_pend_r[1];
   // Out-of-range reads never touched the RAM, so its stale q must be masked.
   assign m0.readdata      = rd_oor_r[0] ? 32'd0 : ram_readdata;
   assign m1.readdata      = rd_oor_r[1] ? 32'd0 : ram_readdata;

   // Ownership FSM with burst run counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_r   <= OWN_NONE;
         last_r    <= 1'b1;
         run_cnt_r <= 8'd0;
      end else if (grant0_s) begin
         owner_r   <= OWN_M0;
         last_r    <= 1'b0;
         run_cnt_r <= (owner_r != OWN_M0) ? 8'd1 : sat_inc(run_cnt_r);
      end else if (grant1_s) begin
         owner_r   <= OWN_M1;
         last_r    <= 1'b1;
         run_cnt_r <= (owner_r != OWN_M1) ? 8'd1 : sat_inc(run_cnt_r);
      end else begin
         owner_r   <= OWN_NONE;
         run_cnt_r <= 8'd0;
      end
   end

   // Read-return tracking, one slot per master, with the range status alongside.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend_r <= 2'b00;
         rd_oor_r  <= 2'b00;
      end else begin
         rd_pend_r <= {grant1_s & gnt_read_s, grant0_s & gnt_read_s};
         rd_oor_r  <= {grant1_s & gnt_read_s & ~in_range_s,
                       grant0_s & gnt_read_s & ~in_range_s};
      end
   end

   // Sticky first-error capture; a new error in the clearing cycle is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_flag   <= 1'b0;
         err_addr   <= '0;
         err_master <= 1'b0;
      end else if (err_event_s && (!err_flag || err_clear)) begin
         err_flag   <= 1'b1;
         err_addr   <= ram_address;
         err_master <= grant1_s;
      end else if (err_clear) begin
         err_flag   <= 1'b0;
         err_addr   <= '0;
         err_master <= 1'b0;
      end
   end
endmodule

// File: tb/tb_nios2_hello_ram_arbiter.sv
// Directed bench for the RAM arbiter: read responses are scoreboarded against
// hand-computed data and due cycles; grant/error behaviour is checked per cycle.
module tb_nios2_hello_ram_arbiter;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] ram_address;
   logic [3:0]        ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken;
   logic [31:0]       ram_writedata;
   logic [31:0]       ram_readdata;
   logic              ram_reset_req = 1'b0;
   logic              err_clear = 1'b0;
   logic              err_flag, err_master;
   logic [ADDR_W-1:0] err_addr;

   nios2_hello_ram_arbiter_if #(.ADDR_W(ADDR_W)) m0_bus ();
   nios2_hello_ram_arbiter_if #(.ADDR_W(ADDR_W)) m1_bus ();

   nios2_hello_ram_arbiter #(.ADDR_W(ADDR_W), .DEPTH(5120), .MAX_BURST(8)) dut (
      .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken),
      .ram_readdata(ram_readdata), .ram_reset_req(ram_reset_req),
      .err_clear(err_clear), .err_flag(err_flag), .err_addr(err_addr),
      .err_master(err_master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM stub: registered q, byte-enabled writes.
   logic [31:0] mem [0:8191];
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
         end
         ram_readdata <= mem[ram_address];
      end
   end

   typedef struct { logic [31:0] data; int due; } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (m0_bus.readdatavalid) begin
            if (q0.size() == 0) chk1("m0 unexpected readdatavalid", m0_bus.readdatavalid, 1'b0);
            else begin
               e = q0.pop_front();
               chk("m0 readdata", m0_bus.readdata, e.data);
               chk("m0 readdatavalid cycle", 32'(cyc), 32'(e.due));
            end
         end
         if (m1_bus.readdatavalid) begin
            if (q1.size() == 0) chk1("m1 unexpected readdatavalid", m1_bus.readdatavalid, 1'b0);
            else begin
               e = q1.pop_front();
               chk("m1 readdata", m1_bus.readdata, e.data);
               chk("m1 readdatavalid cycle", 32'(cyc), 32'(e.due));
            end
         end
      end
   endtask

   task automatic idle_all();
      m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
      m0_bus.byteenable = 4'h0; m0_bus.writedata = 32'd0; m0_bus.lock = 1'b0;
      m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
      m1_bus.byteenable = 4'h0; m1_bus.writedata = 32'd0; m1_bus.lock = 1'b0;
   endtask

   task automatic drive(input int m, input logic rd, input logic wr, input logic [12:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
      if (m == 0) begin
         m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
         m0_bus.writedata = data; m0_bus.byteenable = be;
      end else begin
         m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
         m1_bus.writedata = data; m1_bus.byteenable = be;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // One uncontended access; expects zero wait states.
   task automatic do_acc(input int m, input logic wr, input logic [12:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic exp_cs,
                         input logic exp_resp, input logic [31:0] exp_rd);
      exp_t e;
      drive(m, ~wr, wr, addr, data, be);
      @(negedge clk);
      chk1($sformatf("m%0d waitrequest @%0d", m, addr),
           (m == 0) ? m0_bus.waitrequest : m1_bus.waitrequest, 1'b0);
      chk1($sformatf("ram_chipselect @%0d", addr), ram_chipselect, exp_cs);
      chk1($sformatf("ram_write @%0d", addr), ram_write, exp_cs & wr);
      if (!wr && exp_resp) begin
         e.data = exp_rd;
         e.due  = cyc + 1;
         if (m == 0) q0.push_back(e); else q1.push_back(e);
      end
      step();
      idle_all();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      fork
         monitor();
      join_none

      // Reset state, with m0 requesting while reset is held.
      idle_all();
      m0_bus.read = 1'b1;
      @(negedge clk);
      chk1("reset m0 waitrequest", m0_bus.waitrequest, 1'b1);
      chk1("reset m1 waitrequest", m1_bus.waitrequest, 1'b0);
      chk1("reset ram_chipselect", ram_chipselect, 1'b0);
      chk1("reset ram_write", ram_write, 1'b0);
      chk1("reset m0 readdatavalid", m0_bus.readdatavalid, 1'b0);
      chk1("reset m1 readdatavalid", m1_bus.readdatavalid, 1'b0);
      chk1("reset err_flag", err_flag, 1'b0);
      chk("reset err_addr", {19'd0, err_addr}, 32'd0);
      chk1("reset err_master", err_master, 1'b0);
      chk1("ram_clken", ram_clken, 1'b1);
      do_reset();

      // Basic write/read, byte enables, back-to-back reads.
      do_acc(0, 1'b1, 13'h010, 32'hA5A5_1234, 4'hF, 1'b1, 1'b0, 32'd0);
      do_acc(0, 1'b1, 13'h011, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'd0);
      do_acc(0, 1'b1, 13'h011, 32'hDEAD_BEEF, 4'b0101, 1'b1, 1'b0, 32'd0);
      do_acc(0, 1'b0, 13'h010, 32'd0, 4'hF, 1'b1, 1'b1, 32'hA5A5_1234);
      do_acc(0, 1'b0, 13'h011, 32'd0, 4'hF, 1'b1, 1'b1, 32'h00AD_00EF);
      do_acc(0, 1'b0, 13'h010, 32'd0, 4'hF, 1'b1, 1'b1, 32'hA5A5_1234);
      step();

      // Continuous contention from reset: 8 grants each, alternating.
      do_reset();
      drive(0, 1'b0, 1'b1, 13'h020, 32'h1, 4'hF);
      drive(1, 1'b0, 1'b1, 13'h021, 32'h2, 4'hF);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk1($sformatf("contend m0 waitrequest c%0d", i), m0_bus.waitrequest, 1'((i / 8) % 2));
         chk1($sformatf("contend m1 waitrequest c%0d", i), m1_bus.waitrequest, 1'(1 - (i / 8) % 2));
         chk($sformatf("contend ram_address c%0d", i), {19'd0, ram_address},
             ((i / 8) % 2 == 1) ? 32'h21 : 32'h20);
         step();
      end

      // Lock: m1 holds past the burst limit, releases when lock drops.
      do_reset();
      m1_bus.lock = 1'b1;
      drive(1, 1'b0, 1'b1, 13'h040, 32'h3, 4'hF);
      @(negedge clk);
      chk1("lock m1 first grant", m1_bus.waitrequest, 1'b0);
      step();
      drive(0, 1'b0, 1'b1, 13'h041, 32'h4, 4'hF);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk1($sformatf("lock m0 waitrequest c%0d", i), m0_bus.waitrequest, 1'b1);
         chk1($sformatf("lock m1 waitrequest c%0d", i), m1_bus.waitrequest, 1'b0);
         step();
      end
      m1_bus.lock = 1'b0;
      @(negedge clk);
      chk1("unlock m0 waitrequest", m0_bus.waitrequest, 1'b0);
      chk1("unlock m1 waitrequest", m1_bus.waitrequest, 1'b1);
      step();

      // Range boundary and error capture.
      do_reset();
      do_acc(0, 1'b1, 13'd5119, 32'h1357_9BDF, 4'hF, 1'b1, 1'b0, 32'd0);
      do_acc(0, 1'b0, 13'd5119, 32'd0, 4'hF, 1'b1, 1'b1, 32'h1357_9BDF);
      do_acc(0, 1'b1, 13'd5120, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'd0);
      do_acc(1, 1'b0, 13'd6000, 32'd0, 4'hF, 1'b0, 1'b1, 32'd0);
      @(negedge clk);
      chk1("err_flag after oor", err_flag, 1'b1);
      chk("err_addr after oor", {19'd0, err_addr}, 32'd5120);
      chk1("err_master after oor", err_master, 1'b0);
      step();
      err_clear = 1'b1;
      do_acc(1, 1'b1, 13'd7000, 32'h5, 4'hF, 1'b0, 1'b0, 32'd0);
      err_clear = 1'b0;
      @(negedge clk);
      chk1("err_flag set-wins", err_flag, 1'b1);
      chk("err_addr set-wins", {19'd0, err_addr}, 32'd7000);
      chk1("err_master set-wins", err_master, 1'b1);
      step();
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      @(negedge clk);
      chk1("err_flag cleared", err_flag, 1'b0);
      chk("err_addr cleared", {19'd0, err_addr}, 32'd0);
      chk1("err_master cleared", err_master, 1'b0);
      step();

      // Alternating single reads from the two masters.
      do_reset();
      do_acc(0, 1'b1, 13'h030, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0, 32'd0);
      do_acc(1, 1'b1, 13'h031, 32'hC0FF_EE01, 4'hF, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         do_acc(0, 1'b0, 13'h030, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0BAD_F00D);
         do_acc(1, 1'b0, 13'h031, 32'd0, 4'hF, 1'b1, 1'b1, 32'hC0FF_EE01);
      end
      step();

      // Reset in the cycle after a read is accepted drops its response.
      do_acc(0, 1'b0, 13'h030, 32'd0, 4'hF, 1'b1, 1'b0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk1("reset mid-read m0 readdatavalid", m0_bus.readdatavalid, 1'b0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk1("after reset m0 readdatavalid", m0_bus.readdatavalid, 1'b0);
      step();

      // ram_reset_req blocks new grants; the read accepted just before still returns.
      do_acc(0, 1'b0, 13'h031, 32'd0, 4'hF, 1'b1, 1'b1, 32'hC0FF_EE01);
      ram_reset_req = 1'b1;
      drive(0, 1'b1, 1'b0, 13'h030, 32'd0, 4'hF);
      drive(1, 1'b0, 1'b1, 13'h032, 32'h6, 4'hF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1($sformatf("rrq m0 waitrequest c%0d", i), m0_bus.waitrequest, 1'b1);
         chk1($sformatf("rrq m1 waitrequest c%0d", i), m1_bus.waitrequest, 1'b1);
         chk1($sformatf("rrq ram_chipselect c%0d", i), ram_chipselect, 1'b0);
         step();
      end
      ram_reset_req = 1'b0;
      idle_all();
      step();
      step();

      chk("m0 responses outstanding", 32'(q0.size()), 32'd0);
      chk("m1 responses outstanding", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
